instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ROM_W   = 64;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO holding fetched {pc, instruction} pairs; head is always slot 0.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_entry;
          else                 slot1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_entry;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the two slots are reset as well, so the head outputs read zero rather than X after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head       = slot0_q;
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives ROM address/strobes from the PC, captures words into the fetch buffer,
// and hands {pc, instruction} to decode over valid/ready with branch redirect and wait states.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter int          BUF_DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [31:0]        rom_address,
  output logic               rom_chip_select,
  output logic               rom_output_enable,
  input  logic [ROM_W-1:0]   rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        instr_pc,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || BUF_DEPTH != 2) begin : g_param_check
    $error("instr_fetch_unit: WAIT_CYCLES must be 0..15 and BUF_DEPTH must be 2");
  end

  fetch_state_e state_q, state_d;
  logic [3:0]   wait_q, wait_d;
  logic [31:0]  pc_q, pc_d;

  logic         push, pop, flush, capture;
  logic [1:0]   count, count_after;
  fetch_entry_t head;

  assign capture     = (state_q == ACCESS) && (wait_q == WAIT_LAST);
  assign pop         = instr_valid && instr_ready;
  // Occupancy once this cycle's capture has been pushed; decides whether to keep fetching.
  assign count_after = count + 2'd1 - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect) begin
      flush   = 1'b1;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = IDLE;
      wait_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && count < 2'd2) begin
            state_d = ACCESS;
            wait_d  = 4'd0;
          end
        end
        ACCESS: begin
          if (capture) begin
            push    = 1'b1;
            pc_d    = pc_q + PC_STEP;
            wait_d  = 4'd0;
            state_d = (enable && count_after < 2'd2) ? ACCESS : IDLE;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer u_buf (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry ('{pc: pc_q, instr: rom_data[INSTR_W-1:0]}),
    .head       (head),
    .head_valid (instr_valid),
    .count      (count)
  );

  assign rom_address       = pc_q;
  assign rom_chip_select   = (state_q == ACCESS);
  assign rom_output_enable = (state_q == ACCESS);
  assign instruction       = head.instr;
  assign instr_pc          = head.pc;

  logic unused_bits;
  assign unused_bits = ^{rom_data[ROM_W-1:INSTR_W], redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: one fetch unit with no wait states, one with two, each behind a small ROM model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_word = 32'h9100_2BE0;
      32'h0000_0004: rom_word = 32'hF80F_E3E0;
      32'h0000_000C: rom_word = 32'hF80F_F3E0;
      32'h0000_0018: rom_word = 32'h17FF_FFF9;
      default:       rom_word = 32'hA000_0000 | a;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- DUT with WAIT_CYCLES = 0 ----------------
  logic        reset0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0, redir0 = 1'b0;
  logic [31:0] rpc0 = '0;
  logic [31:0] addr0, instr0, ipc0;
  logic        cs0, oe0, valid0;
  wire  [63:0] rom_data0;
  assign rom_data0 = (cs0 && oe0) ? {32'hFFFF_FFFF, rom_word(addr0)} : {64{1'bz}};

  instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(0), .BUF_DEPTH(2)) dut0 (
    .clock(clk), .reset(reset0), .enable(en0),
    .rom_address(addr0), .rom_chip_select(cs0), .rom_output_enable(oe0), .rom_data(rom_data0),
    .instr_valid(valid0), .instr_ready(rdy0), .instruction(instr0), .instr_pc(ipc0),
    .redirect(redir0), .redirect_pc(rpc0)
  );

  // ---------------- DUT with WAIT_CYCLES = 2 ----------------
  logic        reset2 = 1'b1, en2 = 1'b0, rdy2 = 1'b0, redir2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic [31:0] addr2, instr2, ipc2;
  logic        cs2, oe2, valid2;
  logic [1:0]  held2;
  wire  [63:0] rom_data2;
  // Slow ROM: data is only on the bus in the third cycle an address is held; Z otherwise.
  always @(posedge clk) begin
    if (reset2 || !cs2 || held2 == 2'd2) held2 <= 2'd0;
    else                                 held2 <= held2 + 2'd1;
  end
  assign rom_data2 = (cs2 && oe2 && held2 == 2'd2) ? {32'h0, rom_word(addr2)} : {64{1'bz}};

  instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(2), .BUF_DEPTH(2)) dut2 (
    .clock(clk), .reset(reset2), .enable(en2),
    .rom_address(addr2), .rom_chip_select(cs2), .rom_output_enable(oe2), .rom_data(rom_data2),
    .instr_valid(valid2), .instr_ready(rdy2), .instruction(instr2), .instr_pc(ipc2),
    .redirect(redir2), .redirect_pc(rpc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, " cs"}, 64'(cs0), 64'd0);
    check({tag, " oe"}, 64'(oe0), 64'd0);
    check({tag, " addr"}, 64'(addr0), 64'h0);
    check({tag, " valid"}, 64'(valid0), 64'd0);
    check({tag, " instr"}, 64'(instr0), 64'h0);
    check({tag, " ipc"}, 64'(ipc0), 64'h0);
  endtask

  typedef struct {
    logic        en, rdy, redir;
    logic [31:0] rpc;
    logic        exp_cs;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] got_pc[3];
    logic [31:0] got_in[3];
    int n;

    // Straight-line stream, redirect to misaligned target, PC wrap, enable dropped.
    vecs[0]  = '{1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0};
    vecs[1]  = '{1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'h9100_2BE0};
    vecs[2]  = '{1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'hF80F_E3E0};
    vecs[3]  = '{1, 1, 0, 32'h0,         1, 32'hC,         1, 32'h8,         32'hA000_0008};
    vecs[4]  = '{1, 1, 1, 32'h1B,        0, 32'h18,        0, 32'h0,         32'h0};
    vecs[5]  = '{1, 1, 0, 32'h0,         1, 32'h18,        0, 32'h0,         32'h0};
    vecs[6]  = '{1, 1, 0, 32'h0,         1, 32'h1C,        1, 32'h18,        32'h17FF_FFF9};
    vecs[7]  = '{1, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0};
    vecs[8]  = '{1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0};
    vecs[9]  = '{1, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[10] = '{1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'h9100_2BE0};
    vecs[11] = '{0, 1, 0, 32'h0,         0, 32'h8,         1, 32'h4,         32'hF80F_E3E0};
    vecs[12] = '{0, 1, 0, 32'h0,         0, 32'h8,         0, 32'h0,         32'h0};

    tick();
    tick();
    check_reset0("reset");

    reset0 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      en0 = vecs[i].en; rdy0 = vecs[i].rdy; redir0 = vecs[i].redir; rpc0 = vecs[i].rpc;
      tick();
      check($sformatf("vec%0d cs", i), 64'(cs0), 64'(vecs[i].exp_cs));
      check($sformatf("vec%0d oe", i), 64'(oe0), 64'(vecs[i].exp_cs));
      check($sformatf("vec%0d addr", i), 64'(addr0), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d valid", i), 64'(valid0), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d ipc", i), 64'(ipc0), 64'(vecs[i].exp_pc));
        check($sformatf("vec%0d instr", i), 64'(instr0), 64'(vecs[i].exp_instr));
      end
    end
    redir0 = 1'b0;

    // Reset in the middle of an access with one entry buffered.
    en0 = 1'b1; rdy0 = 1'b0;
    tick();
    tick();
    check("midacc pre valid", 64'(valid0), 64'd1);
    check("midacc pre cs", 64'(cs0), 64'd1);
    reset0 = 1'b1;
    tick();
    check_reset0("midacc reset");

    // Stall from start: two captures, then strobes drop with the head held.
    reset0 = 1'b0;
    tick();
    check("stall first addr", 64'(addr0), 64'h0);
    tick();
    check("stall head pc", 64'(ipc0), 64'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d cs", k), 64'(cs0), 64'd0);
      check($sformatf("stall%0d addr", k), 64'(addr0), 64'h8);
      check($sformatf("stall%0d valid", k), 64'(valid0), 64'd1);
      check($sformatf("stall%0d ipc", k), 64'(ipc0), 64'h0);
      check($sformatf("stall%0d instr", k), 64'(instr0), 64'h9100_2BE0);
      tick();
    end
    rdy0 = 1'b1;
    n = 0;
    for (int c = 0; c < 12 && n < 3; c++) begin
      if (valid0 && rdy0) begin
        got_pc[n] = ipc0;
        got_in[n] = instr0;
        n++;
      end
      tick();
    end
    check("drain count", 64'(n), 64'd3);
    if (n == 3) begin
      check("drain pc0", 64'(got_pc[0]), 64'h0);
      check("drain pc1", 64'(got_pc[1]), 64'h4);
      check("drain pc2", 64'(got_pc[2]), 64'h8);
      check("drain in0", 64'(got_in[0]), 64'h9100_2BE0);
      check("drain in1", 64'(got_in[1]), 64'hF80F_E3E0);
      check("drain in2", 64'(got_in[2]), 64'hA000_0008);
    end

    // Redirect with the buffer full: stale entries never reach decode.
    reset0 = 1'b1; rdy0 = 1'b0;
    tick();
    reset0 = 1'b0;
    tick();
    tick();
    tick();
    check("full addr", 64'(addr0), 64'h8);
    check("full valid", 64'(valid0), 64'd1);
    redir0 = 1'b1; rpc0 = 32'hC;
    tick();
    redir0 = 1'b0;
    check("flush valid", 64'(valid0), 64'd0);
    check("flush addr", 64'(addr0), 64'hC);
    rdy0 = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      if (valid0) n = 1;
      else tick();
    end
    check("redir delivered", 64'(n), 64'd1);
    if (n == 1) begin
      check("redir ipc", 64'(ipc0), 64'hC);
      check("redir instr", 64'(instr0), 64'hF80F_F3E0);
    end

    // Two wait states: address held three cycles, one instruction per three cycles.
    reset2 = 1'b0; en2 = 1'b1; rdy2 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("ws c%0d cs", c), 64'(cs2), 64'd1);
      check($sformatf("ws c%0d addr", c), 64'(addr2), (c < 4) ? 64'h0 : (c < 7) ? 64'h4 : 64'h8);
      check($sformatf("ws c%0d valid", c), 64'(valid2), (c == 4 || c == 7) ? 64'd1 : 64'd0);
      if (c == 4) begin
        check("ws ipc0", 64'(ipc2), 64'h0);
        check("ws instr0", 64'(instr2), 64'h9100_2BE0);
      end
      if (c == 7) begin
        check("ws ipc1", 64'(ipc2), 64'h4);
        check("ws instr1", 64'(instr2), 64'hF80F_E3E0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
